wb_data_select: RTL
===================

# wb_data_select

Parametrised, registered write-back data selector for the multicycle datapath. It generalises the register-file write-data multiplexer to NSRC sources of WIDTH bits. It adds a per-source ready handshake, so slow producers such as mult/div HI/LO can stall the write-back. It also flags illegal select codes and producer timeouts instead of silently holding a stale value. It sits between the functional-unit outputs (LS, HI, LO, shift register, constants, sign-extend, ALUOut) and the register-file write-data port.

## Interface
- WIDTH, 32, data width of every source and of the output
- NSRC, 7, number of connected sources; legal select codes 0..NSRC-1
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NSRC
- TIMEOUT, 34, maximum WAIT cycles before abort; must be >= 1

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request a capture from source sel; sampled only in IDLE
- sel  input  SEL_W  source index, sampled with start
- src_data  input  NSRC*WIDTH  packed sources, source i at bits [i*WIDTH +: WIDTH]
- src_ready  input  NSRC  source i holds valid data when bit i is high
- data_out  output  WIDTH  last captured value, registered
- valid_out  output  1  one-cycle pulse: data_out was updated this cycle
- busy  output  1  high while in WAIT
- err_illegal  output  1  one-cycle pulse: start with sel >= NSRC
- err_timeout  output  1  one-cycle pulse: WAIT exceeded TIMEOUT cycles

## Operation
- States: IDLE, WAIT.
- Reset values: state IDLE, data_out 0, valid_out 0, busy 0, err_illegal 0, err_timeout 0, sel_q 0, wait counter 0.
- IDLE with start=0: nothing changes. All pulse outputs return to 0.
- IDLE, start=1, sel >= NSRC: err_illegal=1 next cycle. data_out is unchanged. The block stays in IDLE.
- IDLE, start=1, legal sel, src_ready[sel]=1 (fast path): data_out <= src_data[sel] and valid_out=1 next cycle. The block stays in IDLE.
- IDLE, start=1, legal sel, src_ready[sel]=0: sel_q <= sel, counter <= 0, go to WAIT, busy=1.
- WAIT, src_ready[sel_q]=1: data_out <= src_data[sel_q], valid_out=1 next cycle, busy=0, go to IDLE.
- WAIT, src_ready[sel_q]=0, counter == TIMEOUT-1: err_timeout=1 next cycle. data_out is unchanged. busy=0, go to IDLE.
- WAIT otherwise: counter increments. The counter is $clog2(TIMEOUT+1) bits wide and never wraps.
- start and sel are ignored in WAIT. No queueing; a request issued while busy is lost. The controller must not issue it.
- Ready of the captured source wins over timeout in the same cycle.
- Data is sampled only on the capture edge. Later changes on src_data do not affect data_out.
- Readies of unselected sources are ignored.

## Timing
- Fast-path latency: start at edge k gives valid_out and the new data_out during cycle k+1.
- Stalled latency: ready first high before edge k+n gives valid_out during cycle k+n+1, for n in 1..TIMEOUT.
- Timeout: start at edge k with ready never high gives err_timeout during cycle k+TIMEOUT+1. busy is high during cycles k+1..k+TIMEOUT.
- Each pulse output lasts exactly one cycle. At most one of valid_out, err_illegal, err_timeout is high in any cycle.
- Back-to-back: a new start is accepted in the same cycle valid_out or err_* is high, since the block is in IDLE.
- Reset asserted mid-WAIT: on that edge the block returns to IDLE with all outputs at reset values. No valid_out or err_timeout is produced for the aborted request.

## Test plan
- Reset, then start sel=6 with src_data[6]=0x0000_00E3 and ready[6]=1 -> valid_out=1 one cycle later, data_out=0x0000_00E3, busy never high.
- Start sel=1 with ready[1]=0, then raise ready[1] after 5 cycles with HI=0xDEAD_BEEF -> busy high for 5 cycles, then valid_out=1 and data_out=0xDEAD_BEEF.
- Start sel=7 (NSRC=7) -> err_illegal pulse, data_out keeps its previous value, busy stays 0.
- Start sel=2 with ready[2] held 0 -> busy for 34 cycles, then err_timeout pulse, data_out unchanged. Next start with sel=0 and ready[0]=1 completes normally.
- Start sel=3 with ready[3]=0, toggle start/sel during WAIT, then assert reset at WAIT cycle 10 -> all outputs 0, no valid_out, no err_timeout.
- Ready for sel_q rises on the cycle the counter reaches TIMEOUT-1 -> valid_out with captured data, no err_timeout.

Source files
------------

// File: rtl/wb_data_select_if.sv
// Write-back data selector bus: producer sources and requests in, selected
// write-data and status pulses out.
interface wb_data_select_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 7,
  parameter int unsigned SEL_W = 3
);
  logic                    start;
  logic [SEL_W-1:0]        sel;
  logic [NSRC*WIDTH-1:0]   src_data;
  logic [NSRC-1:0]         src_ready;
  logic [WIDTH-1:0]        data_out;
  logic                    valid_out;
  logic                    busy;
  logic                    err_illegal;
  logic                    err_timeout;

  modport master (
    output start, sel, src_data, src_ready,
    input  data_out, valid_out, busy, err_illegal, err_timeout
  );

  modport slave (
    input  start, sel, src_data, src_ready,
    output data_out, valid_out, busy, err_illegal, err_timeout
  );
endinterface

// File: rtl/wb_data_select.sv
// Registered write-back data selector with per-source ready handshake,
// illegal-select detection and producer timeout.
module wb_data_select #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NSRC    = 7,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned TIMEOUT = 34
) (
  input  logic             clk,
  input  logic             reset,
  wb_data_select_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt;

  logic [SEL_W-1:0]   cur_sel_c;
  logic [WIDTH-1:0]   cur_data_c;
  logic               cur_ready_c;
  logic               sel_legal_c;

  // Source mux: request select in IDLE, latched select while waiting.
  // Out-of-range codes select nothing, so no part-select runs off the bus.
  always_comb begin
    cur_sel_c   = (state == WAIT) ? sel_q : bus.sel;
    sel_legal_c = 32'(bus.sel) < NSRC;
    cur_data_c  = '0;
    cur_ready_c = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(cur_sel_c) == i) begin
        cur_data_c  = bus.src_data[i*WIDTH +: WIDTH];
        cur_ready_c = bus.src_ready[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      sel_q           <= '0;
      cnt             <= '0;
      bus.data_out    <= '0;
      bus.valid_out   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.valid_out   <= 1'b0;
      bus.err_illegal <= 1'b0;
      bus.err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (!sel_legal_c) begin
              bus.err_illegal <= 1'b1;
            end else if (cur_ready_c) begin
              bus.data_out  <= cur_data_c;
              bus.valid_out <= 1'b1;
            end else begin
              sel_q    <= bus.sel;
              cnt      <= '0;
              state    <= WAIT;
              bus.busy <= 1'b1;
            end
          end
        end
        WAIT: begin
          // Ready of the latched source takes priority over the timeout.
          if (cur_ready_c) begin
            bus.data_out  <= cur_data_c;
            bus.valid_out <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.err_timeout <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
